deserializer: RTL and testbench

- Receiving end of the serial link driven by the serializer: samples a 1-bit stream qualified by a per-bit enable strobe and reassembles Width-bit parallel words.
- Presents each completed word with a one-cycle valid pulse.
- Flags frames truncated by an early enable drop.
- Sits directly on the serializer's data_o/ena_o pair, feeding parallel logic downstream.

---
 rtl/deserializer_pkg.sv | 11 +
 rtl/deserializer.sv | 85 ++++++++
 tb/tb_deserializer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
package deserializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int WidthDefault = 8;

endpackage

// File: rtl/deserializer.sv
// Reassembles Width-bit words from an enable-qualified serial stream;
// pulses valid_o on a complete frame and err_o on an early enable drop.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int Width    = WidthDefault,
    parameter bit MsbFirst = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_i,
    input  logic             ena_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int CW = $clog2(Width);
    localparam logic [CW-1:0] LAST = CW'(Width - 1);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [Width-1:0] r_shift;
    logic [Width-1:0] r_data;
    logic             r_valid;
    logic             r_err;
    logic [Width-1:0] w_shift_nxt;

    // The incoming bit is folded in combinationally so the final word can be
    // captured at the same edge that samples its last bit.
    generate
        if (MsbFirst) begin : g_msb
            assign w_shift_nxt = {r_shift[Width-2:0], data_i};
        end else begin : g_lsb
            assign w_shift_nxt = {data_i, r_shift[Width-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ena_i) begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= CW'(1);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!ena_i) begin
                        r_err   <= 1'b1;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == LAST) begin
                        r_data  <= w_shift_nxt;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign busy_o  = (r_state == SHIFT);
    assign err_o   = r_err;

endmodule

// File: tb/tb_deserializer.sv
// Directed vector bench for the deserializer, MSB-first and LSB-first builds.
module tb_deserializer;

    typedef struct {
        logic       rst;
        logic       ena;
        logic       din;
        logic [7:0] data;
        logic       valid;
        logic       busy;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_m, ena_m, din_m;
    logic [7:0] data_m;
    logic       valid_m, busy_m, err_m;
    logic       rst_l, ena_l, din_l;
    logic [7:0] data_l;
    logic       valid_l, busy_l, err_l;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vq[$];

    always #10 clk = ~clk;

    deserializer #(.Width(8), .MsbFirst(1'b1)) u_msb (
        .clk_i(clk), .rst_i(rst_m), .data_i(din_m), .ena_i(ena_m),
        .data_o(data_m), .valid_o(valid_m), .busy_o(busy_m), .err_o(err_m)
    );

    deserializer #(.Width(8), .MsbFirst(1'b0)) u_lsb (
        .clk_i(clk), .rst_i(rst_l), .data_i(din_l), .ena_i(ena_l),
        .data_o(data_l), .valid_o(valid_l), .busy_o(busy_l), .err_o(err_l)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ena, input logic din,
                       input logic [7:0] data, input logic valid,
                       input logic busy, input logic err);
        vec_t v;
        v.rst = rst; v.ena = ena; v.din = din; v.data = data;
        v.valid = valid; v.busy = busy; v.err = err;
        vq.push_back(v);
    endtask

    // One frame sent first-bit-first from word[7] down; previous word held until the last edge.
    task automatic add_frame(input logic [7:0] word, input logic [7:0] prev);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) add(1'b1, 1'b1, word[7-i], prev, 1'b0, 1'b1, 1'b0);
            else       add(1'b1, 1'b1, word[7-i], word, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic step_m(input logic rst, input logic ena, input logic din);
        rst_m = rst; ena_m = ena; din_m = din;
        @(posedge clk); #1;
    endtask

    task automatic step_l(input logic rst, input logic ena, input logic din);
        rst_l = rst; ena_l = ena; din_l = din;
        @(posedge clk); #1;
    endtask

    task automatic lsb_frame(input logic [7:0] seq, input logic [7:0] exp, input string tag);
        for (int i = 0; i < 8; i++) begin
            step_l(1'b1, 1'b1, seq[7-i]);
            if (i < 7) check({tag, " busy"}, {7'd0, busy_l}, 8'd1);
        end
        check({tag, " valid"}, {7'd0, valid_l}, 8'd1);
        check({tag, " data"},  data_l, exp);
        step_l(1'b1, 1'b0, 1'b0);
        check({tag, " valid drop"}, {7'd0, valid_l}, 8'd0);
    endtask

    initial begin
        rst_m = 1'b0; ena_m = 1'b0; din_m = 1'b0;
        rst_l = 1'b0; ena_l = 1'b0; din_l = 1'b0;

        // Reset with ena toggling
        add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add_frame(8'hA5, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        add_frame(8'h3C, 8'hA5);
        add_frame(8'hC3, 8'h3C);
        // Truncation after 5 bits
        add(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        add_frame(8'h0F, 8'hC3);
        add(1'b1, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            step_m(vq[i].rst, vq[i].ena, vq[i].din);
            check($sformatf("vec%0d data", i),  data_m, vq[i].data);
            check($sformatf("vec%0d valid", i), {7'd0, valid_m}, {7'd0, vq[i].valid});
            check($sformatf("vec%0d busy", i),  {7'd0, busy_m},  {7'd0, vq[i].busy});
            check($sformatf("vec%0d err", i),   {7'd0, err_m},   {7'd0, vq[i].err});
        end

        // Reset mid-frame: partial word dropped, no error pulse
        for (int i = 0; i < 4; i++) step_m(1'b1, 1'b1, 1'b1);
        check("midrst pre busy", {7'd0, busy_m}, 8'd1);
        step_m(1'b0, 1'b1, 1'b1);
        check("midrst data", data_m, 8'h00);
        check("midrst busy", {7'd0, busy_m}, 8'd0);
        check("midrst err",  {7'd0, err_m},  8'd0);
        step_m(1'b1, 1'b0, 1'b0);
        check("midrst err after", {7'd0, err_m}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h81;
            step_m(1'b1, 1'b1, w[7-i]);
            if (i < 7) check("post-rst no valid", {7'd0, valid_m}, 8'd0);
        end
        check("post-rst valid", {7'd0, valid_m}, 8'd1);
        check("post-rst data",  data_m, 8'h81);
        check("post-rst err",   {7'd0, err_m}, 8'd0);

        // LSB-first build
        step_l(1'b0, 1'b0, 1'b0);
        check("lsb reset data", data_l, 8'h00);
        step_l(1'b1, 1'b0, 1'b0);
        lsb_frame(8'b10100101, 8'hA5, "lsb a5");
        lsb_frame(8'b11000000, 8'h03, "lsb 03");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
